pc_sequencer: RTL and testbench

//  Next-PC controller for the pipelined datapath; owns the program counter register and selects its next value.

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_target_mux.sv | 43 ++++
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the next-PC controller: state encoding,
// PC width, default reset/exception addresses and the target alignment helper.
package pc_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] DEF_RESET_ADDR = 32'h0000_0000;
    localparam logic [PC_W-1:0] DEF_EXC_VECTOR = 32'h8000_0180;
    localparam int unsigned     DEF_PC_STEP    = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        REDIR = 2'd3
    } pc_state_e;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Combinational redirect arbiter: picks the highest-priority redirect source,
// aligns its target and flags a misaligned raw target.
module pc_target_mux
    import pc_pkg::*;
(
    input  logic            ExcReq,
    input  logic            JumpReg,
    input  logic [PC_W-1:0] JumpRegTarget,
    input  logic            BranchTaken,
    input  logic [PC_W-1:0] BranchTarget,
    input  logic            Jump,
    input  logic [PC_W-1:0] JumpTarget,
    output logic            Redirect,
    output logic            ExcSel,
    output logic [PC_W-1:0] Target,
    output logic            Misaligned
);

    logic [PC_W-1:0] raw_target;

    // EX-stage sources outrank the ID-stage jump: they belong to an older instruction.
    always_comb begin
        raw_target = '0;
        Redirect   = 1'b0;
        ExcSel     = 1'b0;
        if (ExcReq) begin
            Redirect = 1'b1;
            ExcSel   = 1'b1;
        end else if (JumpReg) begin
            Redirect   = 1'b1;
            raw_target = JumpRegTarget;
        end else if (BranchTaken) begin
            Redirect   = 1'b1;
            raw_target = BranchTarget;
        end else if (Jump) begin
            Redirect   = 1'b1;
            raw_target = JumpTarget;
        end
        Target     = align_pc(raw_target);
        Misaligned = Redirect && !ExcSel && (raw_target[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the PC register, arbitrates fetch/jump/branch/stall.
// Optional exception support is built when the macro PC_EXC_EN is defined.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_ADDR = DEF_RESET_ADDR,
    parameter int unsigned     PC_STEP    = DEF_PC_STEP,
    parameter logic [PC_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Stall,
    input  logic            Jump,
    input  logic [PC_W-1:0] JumpTarget,
    input  logic            BranchTaken,
    input  logic [PC_W-1:0] BranchTarget,
    input  logic            JumpReg,
    input  logic [PC_W-1:0] JumpRegTarget,
    input  logic            ExcReq,
    input  logic [PC_W-1:0] ExcPC,
    output logic [PC_W-1:0] PCResult,
    output logic [PC_W-1:0] PCPlus4,
    output logic            FlushIFID,
    output logic            FetchValid,
    output logic [PC_W-1:0] EPC,
    output pc_state_e       State
);

    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    // Request inputs are level-sampled each rising edge; there is no handshake,
    // a request not acted on in the cycle it is presented is simply lost.
    logic            exc_req;
    logic            redirect;
    logic            exc_sel;
    logic            misaligned;
    logic [PC_W-1:0] target;

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] epc_q;
    logic            flush_q;
    logic            fetch_valid_q;
    pc_state_e       state_q;

`ifdef PC_EXC_EN
    assign exc_req = ExcReq;
`else
    assign exc_req = 1'b0;
    logic unused_exc;
    assign unused_exc = ^{ExcReq, ExcPC, EXC_VECTOR, exc_sel, misaligned};
`endif

    pc_target_mux u_target_mux (
        .ExcReq        (exc_req),
        .JumpReg       (JumpReg),
        .JumpRegTarget (JumpRegTarget),
        .BranchTaken   (BranchTaken),
        .BranchTarget  (BranchTarget),
        .Jump          (Jump),
        .JumpTarget    (JumpTarget),
        .Redirect      (redirect),
        .ExcSel        (exc_sel),
        .Target        (target),
        .Misaligned    (misaligned)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q          <= RESET_ADDR;
            epc_q         <= '0;
            flush_q       <= 1'b0;
            fetch_valid_q <= 1'b0;
            state_q       <= BOOT;
        end else begin
            case (state_q)
                // The boot cycle ignores every request and just steps the PC.
                BOOT: begin
                    pc_q          <= pc_q + STEP;
                    flush_q       <= 1'b0;
                    fetch_valid_q <= 1'b1;
                    state_q       <= RUN;
                end
                default: begin
                    fetch_valid_q <= 1'b1;
                    if (redirect) begin
                        flush_q <= 1'b1;
                        state_q <= REDIR;
`ifdef PC_EXC_EN
                        if (exc_sel) begin
                            pc_q  <= EXC_VECTOR;
                            epc_q <= ExcPC;
                        end else if (misaligned) begin
                            pc_q  <= EXC_VECTOR;
                            epc_q <= pc_q;
                        end else begin
                            pc_q <= target;
                        end
`else
                        pc_q <= target;
`endif
                    end else if (Stall) begin
                        flush_q <= 1'b0;
                        state_q <= HOLD;
                    end else begin
                        pc_q    <= pc_q + STEP;
                        flush_q <= 1'b0;
                        state_q <= RUN;
                    end
                end
            endcase
        end
    end

    assign PCResult   = pc_q;
    assign PCPlus4    = pc_q + STEP;
    assign FlushIFID  = flush_q;
    assign FetchValid = fetch_valid_q;
    assign EPC        = epc_q;
    assign State      = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, an exception sequence, and
// randomized traffic checked against a rule-level model of the next-PC behaviour.
module tb_pc_sequencer;
    import pc_pkg::*;

`ifdef PC_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif
    localparam logic [31:0] VEC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        reset, stall, jump, br, jr, exc;
    logic [31:0] jt, bt, jrt, exc_pc;
    logic [31:0] pc_result, pc_plus4, epc;
    logic        flush, fetch_valid;
    pc_state_e   state;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .Clk           (clk),
        .Reset         (reset),
        .Stall         (stall),
        .Jump          (jump),
        .JumpTarget    (jt),
        .BranchTaken   (br),
        .BranchTarget  (bt),
        .JumpReg       (jr),
        .JumpRegTarget (jrt),
        .ExcReq        (exc),
        .ExcPC         (exc_pc),
        .PCResult      (pc_result),
        .PCPlus4       (pc_plus4),
        .FlushIFID     (flush),
        .FetchValid    (fetch_valid),
        .EPC           (epc),
        .State         (state)
    );

    typedef struct {
        logic        rst, stall, j, br, jr, exc;
        logic [31:0] jt, bt, jrt, epc_in;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [31:0] pc;
        logic        flush;
        logic        fv;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl[$];

    function automatic stim_t st(bit r, bit s, bit j, logic [31:0] jtv, bit b,
                                 logic [31:0] btv, bit x, logic [31:0] xtv);
        stim_t v;
        v.rst = r; v.stall = s; v.j = j; v.jt = jtv; v.br = b; v.bt = btv;
        v.jr = x; v.jrt = xtv; v.exc = 1'b0; v.epc_in = '0;
        return v;
    endfunction

    task automatic add(input stim_t s, input logic [31:0] pc, input bit fl,
                       input bit fv, input logic [31:0] e);
        vec_t v;
        v.s = s; v.pc = pc; v.flush = fl; v.fv = fv; v.epc = e;
        tbl.push_back(v);
    endtask

    task automatic apply(input stim_t s);
        reset = s.rst; stall = s.stall; jump = s.j; jt = s.jt; br = s.br; bt = s.bt;
        jr = s.jr; jrt = s.jrt; exc = s.exc; exc_pc = s.epc_in;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic [31:0] pc, input bit fl,
                             input bit fv, input logic [31:0] e);
        chk({nm, " PCResult"}, pc_result, pc);
        chk({nm, " PCPlus4"}, pc_plus4, pc + 32'd4);
        chk({nm, " FlushIFID"}, {31'd0, flush}, {31'd0, fl});
        chk({nm, " FetchValid"}, {31'd0, fetch_valid}, {31'd0, fv});
        chk({nm, " EPC"}, epc, e);
    endtask

    task automatic step(input stim_t s);
        apply(s);
        @(posedge clk);
        #1;
    endtask

    // Reference model: state of the fetch unit described by its rules.
    logic [31:0] m_pc, m_epc;
    logic        m_flush, m_fv, m_boot;

    function automatic void model_step(input stim_t s);
        logic [31:0] cand[4];
        bit          want[4];
        int          win;
        if (s.rst) begin
            m_pc = 32'h0; m_epc = 32'h0; m_flush = 1'b0; m_fv = 1'b0; m_boot = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0; m_fv = 1'b1; m_flush = 1'b0; m_pc = m_pc + 32'd4;
        end else begin
            want = '{EXC_EN && s.exc, s.jr, s.br, s.j};
            cand = '{VEC, s.jrt, s.bt, s.jt};
            win = -1;
            for (int i = 0; i < 4; i++)
                if (want[i] && win < 0) win = i;
            if (win >= 0) begin
                m_flush = 1'b1;
                if (win == 0) begin
                    m_epc = s.epc_in; m_pc = VEC;
                end else if (EXC_EN && (cand[win] % 4 != 0)) begin
                    m_epc = m_pc; m_pc = VEC;
                end else begin
                    m_pc = cand[win] - (cand[win] % 4);
                end
            end else begin
                m_flush = 1'b0;
                if (!s.stall) m_pc = m_pc + 32'd4;
            end
        end
    endfunction

    function automatic logic [31:0] rand_target();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFF0 + $urandom_range(0, 15);
            1:       return $urandom();
            default: return 32'($urandom_range(0, 255)) << 2;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t       idle, s;
        logic [31:0] mis_pc, mis_pc2, e12, e13;
        idle = st(0, 0, 0, 0, 0, 0, 0, 0);
        apply(st(1, 0, 0, 0, 0, 0, 0, 0));

        mis_pc  = EXC_EN ? VEC : 32'h0000_0100;
        mis_pc2 = EXC_EN ? VEC : 32'h0000_0200;
        e12     = EXC_EN ? 32'h0000_0044 : 32'h0;
        e13     = EXC_EN ? VEC : 32'h0;

        add(st(1, 0, 0, 0, 0, 0, 0, 0), 32'h0, 0, 0, 0);
        add(st(1, 0, 0, 0, 0, 0, 0, 0), 32'h0, 0, 0, 0);
        add(idle, 32'h4, 0, 1, 0);
        add(idle, 32'h8, 0, 1, 0);
        add(idle, 32'hC, 0, 1, 0);
        add(idle, 32'h10, 0, 1, 0);
        add(st(0, 1, 0, 0, 0, 0, 0, 0), 32'h10, 0, 1, 0);
        add(st(0, 1, 0, 0, 0, 0, 0, 0), 32'h10, 0, 1, 0);
        add(st(0, 1, 0, 0, 0, 0, 0, 0), 32'h10, 0, 1, 0);
        add(idle, 32'h14, 0, 1, 0);
        add(st(0, 0, 1, 32'h80, 1, 32'h40, 0, 0), 32'h40, 1, 1, 0);
        add(idle, 32'h44, 0, 1, 0);
        add(st(0, 1, 0, 0, 0, 0, 1, 32'h103), mis_pc, 1, 1, e12);
        add(st(0, 0, 1, 32'h202, 0, 0, 0, 0), mis_pc2, 1, 1, e13);
        add(st(0, 1, 0, 0, 0, 0, 0, 0), mis_pc2, 0, 1, e13);
        add(st(0, 0, 0, 0, 1, 32'h400, 1, 32'h300), 32'h300, 1, 1, e13);
        add(st(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0), 32'hFFFF_FFFC, 1, 1, e13);
        add(idle, 32'h0, 0, 1, e13);
        add(idle, 32'h4, 0, 1, e13);
        add(st(1, 0, 1, 32'h500, 0, 0, 0, 0), 32'h0, 0, 0, 0);
        add(st(0, 0, 1, 32'h600, 1, 32'h700, 0, 0), 32'h4, 0, 1, 0);
        add(idle, 32'h8, 0, 1, 0);

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            step(tbl[i].s);
            check_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].flush, tbl[i].fv, tbl[i].epc);
        end

        // Exception request at PC=0x20 racing a jump-register.
        step(st(1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++) step(idle);
        check_all("exc_pre", 32'h20, 0, 1, 0);
        s = st(0, 0, 0, 0, 0, 0, 1, 32'h300);
        s.exc = 1'b1; s.epc_in = 32'h18;
        step(s);
        if (EXC_EN) check_all("exc_take", VEC, 1, 1, 32'h18);
        else        check_all("exc_ignored", 32'h300, 1, 1, 0);
        step(idle);
        if (EXC_EN) check_all("exc_after", VEC + 32'd4, 0, 1, 32'h18);
        else        check_all("exc_after", 32'h304, 0, 1, 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            s.rst    = (i < 2) || ($urandom_range(0, 63) == 0);
            s.stall  = ($urandom_range(0, 2) == 0);
            s.j      = ($urandom_range(0, 3) == 0);
            s.br     = ($urandom_range(0, 5) == 0);
            s.jr     = ($urandom_range(0, 7) == 0);
            s.exc    = ($urandom_range(0, 11) == 0);
            s.jt     = rand_target();
            s.bt     = rand_target();
            s.jrt    = rand_target();
            s.epc_in = $urandom();
            step(s);
            model_step(s);
            check_all($sformatf("rnd%0d", i), m_pc, m_flush, m_fv, m_epc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
